// File: rtl/hash_drv_pkg.sv
// Shared state encoding and PAD sizing for the hash stream driver.
// HASH_DRV_LENGTH_PAD_EN appends the LEN_W-bit message length after the '1' pad marker.
package hash_drv_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    CLEAR,
    WARMUP,
    ABSORB,
    PAD,
    FINAL,
    DONE
  } state_t;

  localparam int PAD_MARKER_CYCLES = 1;

  function automatic int pad_cycles(input int len_w);
`ifdef HASH_DRV_LENGTH_PAD_EN
    return PAD_MARKER_CYCLES + len_w;
`else
    return PAD_MARKER_CYCLES + 0 * len_w;
`endif
  endfunction

endpackage

// File: rtl/hash_drv_serializer.sv
// Word-to-bit serializer, MSB first: an empty register passes the MSB straight through on
// the load cycle, and s_ready rises on bit 0 so back-to-back words leave no gap.
module hash_drv_serializer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              bit_dat,
  output logic              bit_vld,
  output logic              last_bit
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;
  logic              last_q;
  logic              empty;
  logic              on_bit0;
  logic              load;
  logic              shift;

  // cnt counts bits still to appear on bit_dat, including the one shown this cycle
  assign empty    = (cnt == '0);
  assign on_bit0  = (cnt == CNT_W'(1));
  // the next message's first word must not be taken while the last word drains
  assign s_ready  = en & (empty | (on_bit0 & ~last_q));
  assign load     = s_valid & s_ready;
  assign shift    = en & ~empty;
  assign bit_dat  = empty ? (s_valid & s_data[DATA_W-1]) : sr[DATA_W-1];
  assign bit_vld  = en & (~empty | s_valid);
  assign last_bit = en & on_bit0 & last_q;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      sr     <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      last_q <= s_last;
      if (empty) begin
        sr  <= s_data << 1;
        cnt <= CNT_W'(DATA_W - 1);
      end else begin
        sr  <= s_data;
        cnt <= CNT_W'(DATA_W);
      end
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hash_stream_driver.sv
// Feeds a byte stream MSB-first into the NLFSR hash core, then pads, finalises and captures the digest;
// digest_valid rises N+1+FINAL_CYCLES after the first bit (+LEN_W with HASH_DRV_LENGTH_PAD_EN); digest holds until digest_ready.
module hash_stream_driver
  import hash_drv_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int OUT_SIZE      = 64,
  parameter int WARMUP_CYCLES = 128,
  parameter int FINAL_CYCLES  = 256,
  parameter int LEN_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_last,
  output logic                hash_reset,
  output logic                hash_inj,
  input  logic [OUT_SIZE-1:0] hash_o,
  output logic [OUT_SIZE-1:0] digest,
  output logic                digest_valid,
  input  logic                digest_ready,
  output logic                busy,
  output logic                len_ovf
);

  localparam int PAD_CYCLES = pad_cycles(LEN_W);
  localparam int CNT_W      = $clog2(WARMUP_CYCLES + FINAL_CYCLES + PAD_CYCLES + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic             inj_q;
  logic             ser_bit;
  logic             ser_vld;
  logic             ser_last;

  hash_drv_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == CLEAR),
    .en       (state == ABSORB),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .bit_dat  (ser_bit),
    .bit_vld  (ser_vld),
    .last_bit (ser_last)
  );

  // ABSORB takes the serializer bit directly so a word accepted into an empty register costs no bubble
  assign hash_inj = (state == ABSORB) ? ser_bit : inj_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      hash_reset   <= 1'b1;
      inj_q        <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
      len_ovf      <= 1'b0;
      cnt          <= '0;
      len          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s_valid) begin
            state <= CLEAR;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          len_ovf    <= 1'b0;
          len        <= '0;
          cnt        <= '0;
          hash_reset <= 1'b0;
          state      <= WARMUP;
        end
        WARMUP: begin
          if (cnt == CNT_W'(WARMUP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= ABSORB;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ABSORB: begin
          if (ser_vld && len != LEN_MAX) begin
            len <= len + LEN_W'(1);
            if (len == LEN_MAX - LEN_W'(1)) len_ovf <= 1'b1;
          end
          if (ser_last) begin
            inj_q <= 1'b1;
            cnt   <= '0;
            state <= PAD;
          end
        end
        PAD: begin
`ifdef HASH_DRV_LENGTH_PAD_EN
          // len is consumed by shifting; it is rebuilt from zero in CLEAR
          if (cnt == CNT_W'(PAD_CYCLES - 1)) begin
            inj_q <= 1'b0;
            cnt   <= '0;
            state <= FINAL;
          end else begin
            cnt   <= cnt + CNT_W'(1);
            inj_q <= len[LEN_W-1];
            len   <= len << 1;
          end
`else
          inj_q <= 1'b0;
          cnt   <= '0;
          state <= FINAL;
`endif
        end
        FINAL: begin
          if (cnt == CNT_W'(FINAL_CYCLES - 1)) begin
            digest       <= hash_o;
            digest_valid <= 1'b1;
            cnt          <= '0;
            state        <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            hash_reset   <= 1'b1;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_stream_driver.sv
// Bench for hash_stream_driver: small NLFSR core model, scoreboard of expected injected streams and digests.
module tb_hash_stream_driver;

  localparam int WC = 4;
  localparam int FC = 8;
  localparam int LW = 16;
`ifdef HASH_DRV_LENGTH_PAD_EN
  localparam bit LPAD = 1'b1;
`else
  localparam bit LPAD = 1'b0;
`endif
  localparam logic [63:0] H4 = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0]  s_data = '0;
  logic        hash_reset, hash_inj, digest_valid, busy, len_ovf;
  logic        digest_ready = 1'b1;
  logic [63:0] hash_o, digest;

  logic        s4_valid = 1'b0, s4_last = 1'b0, s4_ready;
  logic [7:0]  s4_data = '0;
  logic        hr4, inj4, dv4, busy4, ovf4;
  logic [63:0] hash_o4, digest4;

  always #5 clk = ~clk;

  hash_stream_driver #(.DATA_W(8), .OUT_SIZE(64), .WARMUP_CYCLES(WC), .FINAL_CYCLES(FC), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .hash_reset(hash_reset), .hash_inj(hash_inj), .hash_o(hash_o), .digest(digest),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .busy(busy), .len_ovf(len_ovf));

  hash_stream_driver #(.DATA_W(8), .OUT_SIZE(64), .WARMUP_CYCLES(WC), .FINAL_CYCLES(FC), .LEN_W(4)) dut4 (
    .clk(clk), .reset(reset), .s_valid(s4_valid), .s_ready(s4_ready), .s_data(s4_data), .s_last(s4_last),
    .hash_reset(hr4), .hash_inj(inj4), .hash_o(hash_o4), .digest(digest4),
    .digest_valid(dv4), .digest_ready(1'b1), .busy(busy4), .len_ovf(ovf4));

  assign hash_o4 = H4;

  function automatic logic [63:0] core_step(input logic [63:0] h, input logic b);
    return {h[62:0], h[63] ^ h[5] ^ (h[10] & h[20]) ^ b};
  endfunction

  always @(posedge clk) hash_o <= hash_reset ? 64'h0 : core_step(hash_o, hash_inj);

  typedef struct packed {
    logic [255:0] bits;
    int           nbits;
    logic [63:0]  dig;
    int           hs;
    logic         ovf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] mw[$];
  int         ms[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Expected core input stream: warm-up zeros, message bits with stall bubbles, pad, final zeros
  function automatic exp_t make_exp();
    exp_t e;
    int n, nb;
    logic [63:0] h;
    e = '0;
    n = WC;
    nb = 0;
    foreach (mw[i]) begin
      for (int b = 7; b >= 0; b--) begin
        e.bits[n] = mw[i][b];
        n++;
        nb++;
      end
      if (i < mw.size() - 1) n += ms[i];
    end
    e.bits[n] = 1'b1;
    n++;
    if (LPAD) begin
      for (int b = LW - 1; b >= 0; b--) begin
        e.bits[n] = nb[b];
        n++;
      end
    end
    n += FC;
    h = '0;
    for (int i = 0; i < n - 1; i++) h = core_step(h, e.bits[i]);
    e.nbits = n;
    e.dig   = h;
    e.hs    = mw.size();
    e.ovf   = 1'b0;
    return e;
  endfunction

  // Monitor: records hash_inj from warm-up start until digest_valid, checks on the digest handshake
  logic [255:0] rec = '0;
  int           rn = 0;
  int           hs_cnt = 0;
  bit           recording = 1'b0;
  bit           prev_hr = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        recording = 1'b0;
        rn = 0;
        hs_cnt = 0;
        prev_hr = 1'b1;
      end else begin
        if (prev_hr && !hash_reset) begin
          recording = 1'b1;
          rn = 0;
          hs_cnt = 0;
          rec = '0;
        end
        prev_hr = hash_reset;
        if (recording && !digest_valid) begin
          if (rn < 256) rec[rn] = hash_inj;
          rn++;
        end
        if (recording && s_valid && s_ready) hs_cnt++;
        if (digest_valid && digest_ready) begin
          if (exp_q.size() == 0) begin
            timeout("unexpected_digest");
          end else begin
            mon_e = exp_q.pop_front();
            check("stream_len", rn, mon_e.nbits);
            check("stream_bits", rec, mon_e.bits);
            check("digest", digest, mon_e.dig);
            check("handshakes", hs_cnt, mon_e.hs);
            check("len_ovf", len_ovf, mon_e.ovf);
          end
          recording = 1'b0;
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) timeout("s_ready_wait");
  endtask

  task automatic send_msg();
    exp_q.push_back(make_exp());
    foreach (mw[i]) begin
      s_data  = mw[i];
      s_last  = (i == mw.size() - 1);
      s_valid = 1'b1;
      wait_ready();
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (i < mw.size() - 1 && ms[i] > 0) begin
        wait_ready();
        repeat (ms[i] + 1) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) timeout("wait_idle");
  endtask

  task automatic send4(input int words);
    int n;
    for (int i = 0; i < words; i++) begin
      s4_data  = 8'h11 * (i + 1);
      s4_last  = (i == words - 1);
      s4_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s4_ready && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!s4_ready) timeout("s4_ready_wait");
      @(posedge clk);
      #1;
      s4_valid = 1'b0;
      s4_last  = 1'b0;
    end
    n = 0;
    while (!dv4 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!dv4) timeout("dv4_wait");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  exp_t        e_ref;
  logic [15:0] lf;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_hash_reset", hash_reset, 1'b1);
    check("rst_hash_inj", hash_inj, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_digest", digest, 64'h0);
    check("rst_digest_valid", digest_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_len_ovf", len_ovf, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // 1: single word, first data bit right after warm-up, then the marker
    mw = '{8'hA5}; ms = '{0};
    send_msg();
    wait_idle();
    check("a5_bits_and_marker", rec[WC +: 9], 9'h1A5);

    // 2: back-to-back words, no bubbles
    mw = '{8'hFF, 8'h00, 8'h81}; ms = '{0, 0, 0};
    send_msg();
    wait_idle();

    // 6a: 2-byte message without stalls; length field when enabled
    mw = '{8'h80, 8'h01}; ms = '{0, 0};
    e_ref = make_exp();
    send_msg();
    wait_idle();
    check("pad_marker", rec[WC + 16], 1'b1);
    if (LPAD) begin
      for (int i = 0; i < 16; i++) lf[15 - i] = rec[WC + 17 + i];
      check("len_field", lf, 16'h0010);
    end

    // 3: three-cycle stall between the words
    mw = '{8'h80, 8'h01}; ms = '{3, 0};
    send_msg();
    wait_idle();
    checks++;
    if (digest === e_ref.dig) begin
      errors++;
      $display("FAIL stall_digest_differs: got %0h, required anything but %0h", digest, e_ref.dig);
    end

    // 4: digest held with digest_ready low; pending s_valid is not consumed
    digest_ready = 1'b0;
    mw = '{8'h3C}; ms = '{0};
    e_ref = make_exp();
    send_msg();
    begin
      int n;
      n = 0;
      while (!digest_valid && n < 500) begin
        @(negedge clk);
        n++;
      end
      if (!digest_valid) timeout("dv_wait");
    end
    s_data = 8'h77; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_dv", digest_valid, 1'b1);
      check("hold_digest", digest, e_ref.dig);
      check("hold_s_ready", s_ready, 1'b0);
      check("hold_busy", busy, 1'b1);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    digest_ready = 1'b1;
    @(posedge clk);
    #1;
    check("after_hs_busy", busy, 1'b0);
    check("after_hs_dv", digest_valid, 1'b0);
    check("after_hs_hash_reset", hash_reset, 1'b1);
    check("after_hs_digest_kept", digest, e_ref.dig);
    wait_idle();

    // 5: reset in the middle of ABSORB, then a clean message
    s_data = 8'hC3; s_last = 1'b1; s_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("abort_busy", busy, 1'b0);
    check("abort_hash_reset", hash_reset, 1'b1);
    check("abort_dv", digest_valid, 1'b0);
    check("abort_digest", digest, 64'h0);
    check("abort_s_ready", s_ready, 1'b0);
    mw = '{8'hA5}; ms = '{0};
    send_msg();
    wait_idle();

    // 6b: 4-bit length counter saturates on a 24-bit message, clears on the next one
    send4(3);
    check("ovf4_set", ovf4, 1'b1);
    check("digest4", digest4, H4);
    repeat (3) @(negedge clk);
    check("ovf4_sticky_idle", ovf4, 1'b1);
    send4(1);
    check("ovf4_cleared", ovf4, 1'b0);
    check("ovf16_clear", len_ovf, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
